// File: rtl/mult_operand_sequencer_if.sv
// mult_operand_sequencer_if
//   Bundles the three handshakes the operand sequencer sits between:
//     upstream   : in_valid / in_ready / in_a / in_b
//     multiplier : mul_start / mul_data / mul_done / mul_result
//     downstream : out_valid / out_ready / out_product / out_timeout
//   plus the busy status flag.
//   modport master : the sequencer side
//   modport slave  : the environment side (feeder, multiplier, consumer)
interface mult_operand_sequencer_if #(
    parameter int DATA_W = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_W-1:0]     in_a;
    logic [DATA_W-1:0]     in_b;
    logic                  mul_start;
    logic [DATA_W-1:0]     mul_data;
    logic                  mul_done;
    logic [2*DATA_W-1:0]   mul_result;
    logic                  out_valid;
    logic                  out_ready;
    logic [2*DATA_W-1:0]   out_product;
    logic                  out_timeout;
    logic                  busy;

    modport master (
        input  in_valid, in_a, in_b, mul_done, mul_result, out_ready,
        output in_ready, mul_start, mul_data, out_valid, out_product,
               out_timeout, busy
    );

    modport slave (
        output in_valid, in_a, in_b, mul_done, mul_result, out_ready,
        input  in_ready, mul_start, mul_data, out_valid, out_product,
               out_timeout, busy
    );
endinterface

// File: rtl/mult_operand_sequencer.sv
// mult_operand_sequencer
//   Feeds operand pairs into the serial repeated-addition multiplier:
//   pulses start, puts A then B on the serial bus, waits for done and
//   presents the product downstream. A zero operand skips the multiplier
//   entirely; a stalled multiplier is abandoned after TIMEOUT_CYCLES wait
//   cycles, returning all-ones with out_timeout set.
//   Ports:
//     clk  - clock, rising edge
//     rst  - asynchronous active-high reset
//     bus  - mult_operand_sequencer_if.master (all handshake signals)
module mult_operand_sequencer #(
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 300,
    parameter int CNT_W          = 9
) (
    input  logic                      clk,
    input  logic                      rst,
    mult_operand_sequencer_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_LOAD_A, S_LOAD_B, S_WAIT, S_OUT
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_W-1:0]     r_a;
    logic [DATA_W-1:0]     r_b;
    logic [CNT_W-1:0]      r_cnt;
    logic [2*DATA_W-1:0]   r_product;
    logic                  r_timeout;
    logic [DATA_W-1:0]     w_mul_data;
    logic                  w_zero;
    logic                  w_expired;

    assign w_zero    = (bus.in_a == '0) || (bus.in_b == '0);
    assign w_expired = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mul_data  = '0;
        case (r_state)
            S_IDLE:   if (bus.in_valid) w_state_nxt = w_zero ? S_OUT : S_START;
            S_START:  begin w_mul_data = r_a; w_state_nxt = S_LOAD_A; end
            S_LOAD_A: begin w_mul_data = r_a; w_state_nxt = S_LOAD_B; end
            S_LOAD_B: begin w_mul_data = r_b; w_state_nxt = S_WAIT;   end
            S_WAIT: begin
                w_mul_data = r_b;
                // done takes priority over an expiring counter
                if (bus.mul_done || w_expired) w_state_nxt = S_OUT;
            end
            S_OUT:    if (bus.out_ready) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a       <= '0;
            r_b       <= '0;
            r_cnt     <= '0;
            r_product <= '0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (bus.in_valid) begin
                    r_a <= bus.in_a;
                    r_b <= bus.in_b;
                    if (w_zero) begin
                        r_product <= '0;
                        r_timeout <= 1'b0;
                    end
                end
                S_LOAD_B: r_cnt <= '0;
                S_WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    // mul_done is only looked at here, so a late done from an
                    // operation cut short by reset can never produce output
                    if (bus.mul_done) begin
                        r_product <= bus.mul_result;
                        r_timeout <= 1'b0;
                    end else if (w_expired) begin
                        r_product <= '1;
                        r_timeout <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready    = (r_state == S_IDLE);
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.mul_start   = (r_state == S_START);
    assign bus.mul_data    = w_mul_data;
    assign bus.out_valid   = (r_state == S_OUT);
    assign bus.out_product = r_product;
    assign bus.out_timeout = r_timeout;

endmodule

// File: tb/tb_mult_operand_sequencer.sv
module tb_mult_operand_sequencer;
    localparam int DW = 8;
    localparam int TO = 300;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    mult_operand_sequencer_if #(.DATA_W(DW)) bus ();

    mult_operand_sequencer #(.DATA_W(DW), .TIMEOUT_CYCLES(TO), .CNT_W(9)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    // Repeated-addition multiplier model: after start it loads A, then B
    // (clearing P), then adds A once per cycle B times and raises done.
    // It has no reset, like the real block.
    int          m_ph  = 0;
    logic [7:0]  m_a   = '0;
    logic [8:0]  m_cnt = '0;
    logic [15:0] m_p   = '0;
    logic        m_en    = 1'b1;
    logic        m_force = 1'b0;

    always @(posedge clk) begin
        if (bus.mul_start) m_ph <= 1;
        else case (m_ph)
            1: begin m_a <= bus.mul_data; m_ph <= 2; end
            2: begin m_cnt <= {1'b0, bus.mul_data}; m_p <= '0; m_ph <= 3; end
            3: if (m_cnt == 9'd0) m_ph <= 4;
               else begin m_p <= m_p + {8'd0, m_a}; m_cnt <= m_cnt - 9'd1; end
            default: ;
        endcase
    end

    assign bus.mul_done   = ((m_ph == 4) && m_en) || m_force;
    assign bus.mul_result = m_p;

    typedef struct {
        int          starts;
        logic [7:0]  d2, d3;
        int          lat;
        logic [15:0] prod;
        logic        tmo;
        bit          stable, rdy_low, dropped;
    } obs_t;

    typedef struct { int starts; int lat; logic [15:0] prod; logic tmo; } exp_t;

    // Reference behaviour from the block's rules, cycles counted from accept.
    function automatic exp_t model(input int a, input int b, input bit en);
        exp_t e;
        if (a == 0 || b == 0) begin e.starts = 0; e.lat = 1; e.prod = 16'd0; e.tmo = 1'b0; end
        else if (!en)        begin e.starts = 1; e.lat = 4 + TO; e.prod = 16'hFFFF; e.tmo = 1'b1; end
        else                 begin e.starts = 1; e.lat = 6 + b; e.prod = 16'(a * b); e.tmo = 1'b0; end
        return e;
    endfunction

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Drives one pair, observes the response, holds out_ready low for
    // 'hold' cycles, then completes the transfer. Observation only.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int hold, output obs_t o);
        o.starts = 0; o.d2 = '0; o.d3 = '0; o.lat = 0; o.prod = '0; o.tmo = 1'b0;
        o.stable = 1; o.rdy_low = 1; o.dropped = 0;
        bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b;
        step();
        bus.in_valid = 1'b0;
        for (int c = 1; c <= 400; c++) begin
            if (bus.mul_start) o.starts++;
            if (c == 2) o.d2 = bus.mul_data;
            if (c == 3) o.d3 = bus.mul_data;
            if (bus.out_valid) begin o.lat = c; break; end
            step();
        end
        o.prod = bus.out_product; o.tmo = bus.out_timeout;
        if (bus.in_ready !== 1'b0) o.rdy_low = 0;
        for (int h = 0; h < hold; h++) begin
            step();
            if (bus.out_valid !== 1'b1 || bus.out_product !== o.prod || bus.out_timeout !== o.tmo) o.stable = 0;
            if (bus.in_ready !== 1'b0) o.rdy_low = 0;
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        o.dropped = (bus.out_valid === 1'b0) && (bus.in_ready === 1'b1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) step();
        checks++;
        if ({bus.in_ready, bus.busy, bus.out_valid, bus.mul_start} !== 4'b1000) begin
            errors++; $display("FAIL reset_ctrl got=%b want=1000", {bus.in_ready, bus.busy, bus.out_valid, bus.mul_start});
        end
        checks++;
        if ({bus.out_product, bus.out_timeout, bus.mul_data} !== 25'd0) begin
            errors++; $display("FAIL reset_data prod=%h tmo=%b data=%h want 0", bus.out_product, bus.out_timeout, bus.mul_data);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        obs_t o; exp_t e;
        run_op(8'd12, 8'd10, 0, o);
        e = model(12, 10, 1);
        checks++; if (o.starts !== 1)     begin errors++; $display("FAIL basic_start got=%0d want=1", o.starts); end
        checks++; if (o.d2 !== 8'd12)     begin errors++; $display("FAIL basic_dataA got=%0d want=12", o.d2); end
        checks++; if (o.d3 !== 8'd10)     begin errors++; $display("FAIL basic_dataB got=%0d want=10", o.d3); end
        checks++; if (o.prod !== e.prod || o.tmo !== e.tmo) begin
            errors++; $display("FAIL basic_prod got=%0d/%b want=%0d/%b", o.prod, o.tmo, e.prod, e.tmo); end
        checks++; if (o.lat !== e.lat)    begin errors++; $display("FAIL basic_latency got=%0d want=%0d", o.lat, e.lat); end
        checks++; if (!o.dropped)         begin errors++; $display("FAIL basic_handshake got=0 want=1"); end
    endtask

    task automatic test_zero();
        obs_t o;
        logic [7:0] za [2] = '{8'd0, 8'd5};
        logic [7:0] zb [2] = '{8'd77, 8'd0};
        for (int i = 0; i < 2; i++) begin
            run_op(za[i], zb[i], 0, o);
            checks++;
            if (o.starts !== 0 || o.lat !== 1 || o.prod !== 16'd0 || o.tmo !== 1'b0) begin
                errors++; $display("FAIL zero_bypass a=%0d b=%0d starts=%0d lat=%0d prod=%0d tmo=%b want 0/1/0/0",
                                   za[i], zb[i], o.starts, o.lat, o.prod, o.tmo);
            end
        end
    endtask

    task automatic test_max();
        obs_t o; exp_t e;
        run_op(8'd255, 8'd255, 0, o);
        e = model(255, 255, 1);
        checks++;
        if (o.prod !== 16'hFE01 || o.tmo !== 1'b0 || o.lat !== e.lat) begin
            errors++; $display("FAIL max_operands prod=%h tmo=%b lat=%0d want FE01/0/%0d", o.prod, o.tmo, o.lat, e.lat);
        end
    endtask

    task automatic test_backpressure();
        obs_t o;
        run_op(8'd3, 8'd5, 20, o);
        checks++; if (o.prod !== 16'd15) begin errors++; $display("FAIL bp_prod got=%0d want=15", o.prod); end
        checks++; if (!o.stable)  begin errors++; $display("FAIL bp_stable got=0 want=1"); end
        checks++; if (!o.rdy_low) begin errors++; $display("FAIL bp_in_ready_low got=0 want=1"); end
        checks++; if (!o.dropped) begin errors++; $display("FAIL bp_transfer got=0 want=1"); end
        step();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_single got=%b want=0", bus.out_valid); end
    endtask

    task automatic test_timeout();
        obs_t o; exp_t e;
        m_en = 1'b0;
        run_op(8'd3, 8'd4, 0, o);
        m_en = 1'b1;
        e = model(3, 4, 0);
        checks++; if (o.lat !== e.lat) begin errors++; $display("FAIL timeout_latency got=%0d want=%0d", o.lat, e.lat); end
        checks++; if (o.prod !== 16'hFFFF || o.tmo !== 1'b1) begin
            errors++; $display("FAIL timeout_value got=%h/%b want=FFFF/1", o.prod, o.tmo); end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        bit seen;
        bus.in_valid = 1'b1; bus.in_a = 8'd9; bus.in_b = 8'd9;
        step();
        bus.in_valid = 1'b0;
        repeat (5) step();                 // now in WAIT
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.in_ready, bus.busy, bus.out_valid, bus.mul_start} !== 4'b1000 ||
            {bus.out_product, bus.out_timeout, bus.mul_data} !== 25'd0) begin
            errors++; $display("FAIL midreset_state ctrl=%b prod=%h tmo=%b data=%h want 1000/0/0/0",
                               {bus.in_ready, bus.busy, bus.out_valid, bus.mul_start},
                               bus.out_product, bus.out_timeout, bus.mul_data);
        end
        step();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) seen = 1;
        end
        m_force = 1'b1;
        step();
        m_force = 1'b0;
        step();
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) seen = 1;
        checks++; if (seen) begin errors++; $display("FAIL stale_done got=output want=none"); end
        run_op(8'd7, 8'd6, 0, o);
        checks++; if (o.prod !== 16'd42 || o.tmo !== 1'b0) begin
            errors++; $display("FAIL after_reset got=%0d/%b want=42/0", o.prod, o.tmo); end
    endtask

    task automatic test_random();
        obs_t o; exp_t e;
        logic [7:0] a, b;
        for (int i = 0; i < 10; i++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(1, 255));
            if ($urandom_range(0, 3) == 0) b = 8'd0;
            run_op(a, b, int'($urandom_range(0, 3)), o);
            e = model(int'(a), int'(b), 1);
            checks++;
            if (o.prod !== e.prod || o.tmo !== e.tmo || o.lat !== e.lat || o.starts !== e.starts || !o.dropped) begin
                errors++; $display("FAIL random a=%0d b=%0d got=%0d/%b lat=%0d st=%0d want=%0d/%b lat=%0d st=%0d",
                                   a, b, o.prod, o.tmo, o.lat, o.starts, e.prod, e.tmo, e.lat, e.starts);
            end
        end
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_zero();
        test_max();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mult_operand_sequencer.md
Name: mult_operand_sequencer

Overview:
Upstream feeder for the 8-bit repeated-addition multiplier.
- Accepts operand pairs (A, B) on a valid/ready interface.
- Drives the multiplier's start / serial data_in protocol: A, then B.
- Waits for done, captures the 16-bit result and presents it on a valid/ready output.
- Short-circuits zero operands and bounds the wait with a timeout counter, so a stalled multiplier cannot hang the pipeline.

Parameters:
- DATA_W, 8, operand width; the product is 2*DATA_W.
- TIMEOUT_CYCLES, 300, maximum WAIT-state cycles before aborting. Must exceed 2^DATA_W + 4.
- CNT_W, 9, timeout counter width; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand pair available.
- in_ready  out  1  sequencer can accept a pair; high only in IDLE.
- in_a  in  DATA_W  multiplicand A.
- in_b  in  DATA_W  multiplier B.
- mul_start  out  1  start pulse to the multiplier.
- mul_data  out  DATA_W  serial operand bus to the multiplier's data_in.
- mul_done  in  1  multiplier done.
- mul_result  in  2*DATA_W  multiplier product.
- out_valid  out  1  product available.
- out_ready  in  1  downstream accepts product.
- out_product  out  2*DATA_W  captured product.
- out_timeout  out  1  qualifies out_product; 1 means the operation aborted.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async, any state): FSM returns to IDLE. Operand registers, counter, out_product, out_timeout and mul_data clear to 0. mul_start=0, out_valid=0, in_ready=1, busy=0.
- States: IDLE, START, LOAD_A, LOAD_B, WAIT, OUT.
- IDLE: in_ready=1. On in_valid, latch in_a/in_b.
  - If either operand is 0: out_product=0, out_timeout=0, go to OUT. The multiplier is not started.
  - Otherwise go to START.
- START (1 cycle): mul_start=1, mul_data=A.
- LOAD_A (1 cycle): mul_start=0, mul_data=A. The multiplier loads A at the end of this cycle.
- LOAD_B (1 cycle): mul_data=B. The multiplier loads B and clears P. The counter clears to 0.
- WAIT: mul_data=B (held). Counter increments each cycle.
  - mul_done is sampled only in WAIT; done from any earlier operation is ignored.
  - mul_done=1: capture mul_result into out_product, out_timeout=0, go to OUT.
  - Else, if counter == TIMEOUT_CYCLES-1: out_product=all ones, out_timeout=1, go to OUT.
  - If mul_done and the timeout coincide, done wins.
- OUT: out_valid=1; out_product and out_timeout are held stable.
  - out_ready=1: transfer completes, go to IDLE. out_valid drops the next cycle.
  - out_ready=0: remain in OUT indefinitely.
- Timing, accept edge = edge 0:
  - Normal path: mul_start is high in cycle 1, A is on the bus in cycle 2, B in cycle 3, WAIT from cycle 4.
  - out_valid rises the cycle after mul_done is first seen in WAIT.
  - Zero bypass: out_valid is high in cycle 1.
- Back-to-back: in_ready is low in OUT, so a new pair is accepted no earlier than the cycle after the output handshake.
- Width: no arithmetic is performed here. out_product is the multiplier result verbatim, or 0 / all ones as above.
- Reset mid-operation returns the sequencer to IDLE. The multiplier has no reset, so any result it later produces is discarded because done is sampled only in WAIT.

Test Plan:
- A=12, B=10, multiplier model asserts done after B add cycles → mul_start high exactly 1 cycle; mul_data = 12 then 10 on the next two cycles; out_product=120; out_timeout=0.
- A=0, B=77 and A=5, B=0 → mul_start never asserted; out_valid high the cycle after accept; out_product=0.
- A=255, B=255 → out_product=65025 (0xFE01); out_timeout=0; WAIT count does not reach TIMEOUT_CYCLES.
- out_ready held 0 for 20 cycles after out_valid → out_product stable; in_ready=0 throughout; a single transfer occurs when out_ready rises.
- mul_done tied 0, A=3, B=4 → after exactly 300 WAIT cycles out_valid=1, out_timeout=1, out_product=0xFFFF.
- rst pulsed during WAIT, then a stale mul_done pulse, then new pair 7×6 → all outputs 0 after reset; no output from the stale done; next result 42.
